// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed hex 7-seg scanner, frame-synchronous display update; define SEVEN_SEG_LZ_BLANK_EN for leading-zero blanking
module seven_seg_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      load,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic [7:0]                cathode,
   output logic                      frame_done
);
   localparam int TW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [15:0][6:0] SEG = {
      7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
      7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
      7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
      7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };
   logic [TW-1:0]           r_tick;
   logic [IW-1:0]           r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend_val;
   logic [4*NUM_DIGITS-1:0] r_disp_val;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_disp_dp;
   logic                    r_pend_flag;
   logic                    w_step;
   logic                    w_wrap;
   logic                    w_blank;
   logic                    w_lit;
   logic [3:0]              w_nib;
   assign w_step = r_tick == TW'(REFRESH_DIV - 1);
   assign w_wrap = w_step && r_idx == IW'(NUM_DIGITS - 1);
   assign w_nib  = r_disp_val[{r_idx, 2'b00} +: 4];
   assign w_lit  = digit_en[r_idx] && !w_blank;
`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic [IW-1:0] w_msd;
   always_comb begin
      w_msd = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r_disp_val[4*i +: 4] != 4'd0) w_msd = IW'(i);
   end
   // digit 0 can never exceed w_msd, so it is never blanked
   assign w_blank = r_idx > w_msd && !r_disp_dp[r_idx];
`else
   assign w_blank = 1'b0;
`endif
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_tick      <= '0;
         r_idx       <= '0;
         r_pend_val  <= '0;
         r_pend_dp   <= '0;
         r_disp_val  <= '0;
         r_disp_dp   <= '0;
         r_pend_flag <= 1'b0;
         anode       <= '1;
         cathode     <= 8'hFF;
         frame_done  <= 1'b0;
      end else begin
         r_tick <= w_step ? '0 : r_tick + 1'b1;
         if (w_step) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
         if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp;
         end
         // a load on the wrap edge lands in pending while the old pending goes to display
         if (w_wrap && r_pend_flag) begin
            r_disp_val <= r_pend_val;
            r_disp_dp  <= r_pend_dp;
         end
         r_pend_flag <= load || (r_pend_flag && !w_wrap);
         frame_done  <= w_wrap;
         anode       <= ~(NUM_DIGITS'(w_lit) << r_idx);
         cathode     <= {~r_disp_dp[r_idx], SEG[w_nib]};
      end
   end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed checks of scan order, frame-synchronous loads, enables, blanking and reset
module tb_seven_seg_scan;
   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  digit_en = 4'hF;
   logic [3:0]  anode;
   logic [7:0]  cathode;
   logic        frame_done;
   int          total = 0;
   int          passed = 0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
   localparam logic [3:0] ZLIT = 4'b0001;
`else
   localparam logic [3:0] ZLIT = 4'b1111;
`endif
   seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .value(value),
      .dp(dp),
      .load(load),
      .digit_en(digit_en),
      .anode(anode),
      .cathode(cathode),
      .frame_done(frame_done)
   );
   always #5 Clk = ~Clk;
   task automatic tk;
      @(posedge Clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) begin
         passed++;
      end else begin
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   // one 16-cycle frame; cath holds {d3,d2,d1,d0}, lit is the expected lit-digit mask
   task automatic frame(input string tag, input logic [31:0] cath, input logic [3:0] lit,
                        input int la, input logic [15:0] va, input logic [3:0] da,
                        input int lb, input logic [15:0] vb);
      for (int k = 0; k < 16; k++) begin
         int d;
         logic [3:0] ea;
         d = k / 4;
         load = (k == la) || (k == lb);
         if (k == la) begin
            value = va;
            dp = da;
         end
         if (k == lb) begin
            value = vb;
            dp = 4'b0000;
         end
         tk();
         load = 1'b0;
         ea = lit[d] ? ~(4'b0001 << d) : 4'hF;
         chk({tag, "_anode"}, 32'(anode), 32'(ea));
         chk({tag, "_cathode"}, 32'(cathode), 32'(cath[8*d +: 8]));
         chk({tag, "_frame_done"}, 32'(frame_done), 32'(k == 15));
      end
   endtask
   initial begin
      tk();
      tk();
      tk();
      chk("rst_anode", 32'(anode), 32'h0000000F);
      chk("rst_cathode", 32'(cathode), 32'h000000FF);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      Rst = 1'b0;
      frame("f0", 32'hC0C0C0C0, ZLIT, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("f1", 32'hC0C0C0C0, ZLIT, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("f2", 32'hC0C0C0C0, ZLIT, 2, 16'h12AF, 4'b0100, -1, 16'h0);
      frame("f3", 32'hF924888E, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("f4", 32'hF924888E, 4'hF, 3, 16'h1111, 4'h0, 15, 16'h2222);
      frame("f5", 32'hF9F9F9F9, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("f6", 32'hA4A4A4A4, 4'hF, -1, 16'h0, 4'h0, 15, 16'h3333);
      frame("f7", 32'hA4A4A4A4, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0);
      digit_en = 4'b1010;
      frame("f8", 32'hB0B0B0B0, 4'b1010, -1, 16'h0, 4'h0, -1, 16'h0);
      digit_en = 4'hF;
      value = 16'h4444;
      dp = 4'b1111;
      load = 1'b1;
      tk();
      load = 1'b0;
      tk();
      Rst = 1'b1;
      tk();
      tk();
      chk("midrst_anode", 32'(anode), 32'h0000000F);
      chk("midrst_cathode", 32'(cathode), 32'h000000FF);
      chk("midrst_frame_done", 32'(frame_done), 32'h0);
      Rst = 1'b0;
      frame("r0", 32'hC0C0C0C0, ZLIT, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("r1", 32'hC0C0C0C0, ZLIT, -1, 16'h0, 4'h0, -1, 16'h0);
      frame("b0", 32'hC0C0C0C0, ZLIT, 2, 16'h0005, 4'h0, -1, 16'h0);
      frame("b1", 32'hC0C0C092, ZLIT, -1, 16'h0, 4'h0, -1, 16'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit is driven; legal minimum 1.
REQ-003 Port Clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port Rst, input, 1: synchronous, active-high reset.
REQ-005 Port value, input, 4*NUM_DIGITS: hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i, and digit 0 is least significant.
REQ-006 Port dp, input, NUM_DIGITS: decimal point per digit, 1 = lit.
REQ-007 Port load, input, 1: single-cycle pulse that captures value and dp.
REQ-008 Port digit_en, input, NUM_DIGITS: per-digit enable, sampled live; 0 = digit dark.
REQ-009 Port anode, output reg, NUM_DIGITS: active-low digit select.
REQ-010 Port cathode, output reg, 8: active-low; bit 7 = DP, bits 6:0 = {g,f,e,d,c,b,a}.
REQ-011 Port frame_done, output reg, 1: one-cycle pulse at each scan-frame wrap.

Function
REQ-012 Segment encoding for bits 6:0, nibble 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-013 Divider tick_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-014 When tick_cnt = REFRESH_DIV-1, digit index idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-015 A load pulse SHALL copy value/dp into pending registers and set pend_flag.
REQ-016 On the idx wrap (NUM_DIGITS-1 -> 0):
  - if pend_flag = 1, pending SHALL transfer into the display registers and pend_flag SHALL clear;
  - frame_done SHALL pulse in the cycle after the wrap edge.
REQ-017 If load coincides with a wrap while pend_flag = 1:
  - display SHALL receive the old pending;
  - pending SHALL receive the new value;
  - pend_flag SHALL remain 1.
REQ-018 If load coincides with a wrap while pend_flag = 0, the new value SHALL wait for the next wrap.
REQ-019 Display updates SHALL happen only at frame boundaries, with no mid-frame tearing.
REQ-020 anode and cathode SHALL be registered from the current idx and display registers, one cycle of latency.
REQ-021 anode[idx] = 0 only when digit_en[idx] = 1 and the digit is not blanked; all other anode bits = 1.
REQ-022 cathode[7] SHALL be ~dp_disp[idx]; cathode[6:0] SHALL be the encoding of nibble idx of the display register.
REQ-023 When NUM_DIGITS = 1, every digit step SHALL be a wrap.

Reset
REQ-024 While Rst = 1, the following SHALL be forced:
  - tick_cnt = 0, idx = 0;
  - display and pending registers = 0, pend_flag = 0;
  - anode = all 1s, cathode = 8'hFF, frame_done = 0.
REQ-025 Rst asserted mid-frame SHALL discard any pending load.
REQ-026 The first post-reset frame SHALL start at digit 0 with a full REFRESH_DIV dwell.

Configuration
REQ-027 Macro SEVEN_SEG_LZ_BLANK_EN selects leading-zero blanking.
REQ-028 When SEVEN_SEG_LZ_BLANK_EN is defined:
  - digits above the most significant nonzero display nibble SHALL be blanked (anode bit 1);
  - digit 0 SHALL never be blanked;
  - a lit dp SHALL prevent blanking of its digit.
REQ-029 When SEVEN_SEG_LZ_BLANK_EN is undefined, every enabled digit SHALL be driven.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset test: Rst held 3 cycles -> anode = 4'b1111, cathode = 8'hFF, frame_done = 0; first post-reset update -> anode = 4'b1110, cathode = 8'hC0.
REQ-031 Mid-frame load: load with value = 16'h12AF, dp = 4'b0100 -> display unchanged until the wrap; next frame shows:
  - digit0 cathode = 8'h8E;
  - digit1 cathode = 8'h88;
  - digit2 cathode = 8'h24 (DP lit);
  - digit3 cathode = 8'hF9.
REQ-032 Scan order: anode sequence 1110, 1101, 1011, 0111, each held 4 cycles; frame_done pulses once every 16 cycles.
REQ-033 Coincident loads: load 16'h1111 then, on a wrap cycle, load 16'h2222 -> first frame shows 1111, next frame shows 2222.
REQ-034 Digit enable and blanking: digit_en = 4'b1010 -> anode never asserts digits 0 and 2. With SEVEN_SEG_LZ_BLANK_EN and value = 16'h0005 -> only digit 0 lit (cathode = 8'h92).
REQ-035 Reset mid-frame: Rst mid-frame with pend_flag = 1 -> after reset, display = 0 and the pending value is never shown.
